// File: rtl/tick_sync_monitor.sv
// tick_sync_monitor: resynchronizes a slow toggle into clk, emits edge ticks,
// measures the toggle interval, and reports lock and stall.
module tick_sync_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 12000000,
   parameter int TOL         = 2,
   parameter int LOCK_COUNT  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_in,
   output logic             tick,
   output logic             rise,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam int MW = $clog2(LOCK_COUNT + 1);
   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev, chg, prev_valid, match;
   logic [CNT_W-1:0]       gap, gap_n, prev_int;
   logic [CNT_W:0]         diff;
   logic [MW-1:0]          match_cnt;
   // gap_n is the gap value seen in the cycle being registered, so an interval
   // measured on a detected change equals the tick-to-tick distance
   always_comb begin
      chg   = sync[SYNC_STAGES-1] ^ prev;
      gap_n = tick ? CNT_W'(1) : (gap == MAX ? gap : gap + 1'b1);
      diff  = gap_n >= prev_int ? {1'b0, gap_n} - {1'b0, prev_int} : {1'b0, prev_int} - {1'b0, gap_n};
      match = prev_valid && diff <= (CNT_W+1)'(TOL);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync         <= '0;
         prev         <= 1'b0;
         tick         <= 1'b0;
         rise         <= 1'b0;
         gap          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         prev_int     <= '0;
         prev_valid   <= 1'b0;
         match_cnt    <= '0;
         state        <= IDLE;
      end else begin
         sync         <= {sync[SYNC_STAGES-2:0], slow_in};
         prev         <= sync[SYNC_STAGES-1];
         tick         <= chg;
         rise         <= chg & sync[SYNC_STAGES-1];
         gap          <= gap_n;
         period_valid <= 1'b0;
         if (chg) begin
            timeout <= 1'b0;
            if (state == IDLE) begin
               state      <= ACQUIRE;
               prev_valid <= 1'b0;
               match_cnt  <= '0;
            end else begin
               period       <= gap_n;
               period_valid <= 1'b1;
               prev_int     <= gap_n;
               prev_valid   <= 1'b1;
               if (match) begin
                  if (match_cnt != MW'(LOCK_COUNT)) match_cnt <= match_cnt + 1'b1;
                  if (match_cnt >= MW'(LOCK_COUNT - 1)) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end
               end else begin
                  match_cnt <= '0;
                  state     <= ACQUIRE;
                  locked    <= 1'b0;
               end
            end
         end else if (gap_n == CNT_W'(TIMEOUT)) begin
            timeout    <= 1'b1;
            state      <= IDLE;
            locked     <= 1'b0;
            match_cnt  <= '0;
            prev_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tick_sync_monitor.sv
// tb_tick_sync_monitor: directed checks of tick generation, interval, lock and stall.
module tb_tick_sync_monitor;
   logic        clk = 1'b0, rst = 1'b1, slow_in = 1'b0;
   logic        tick, rise, period_valid, locked, timeout;
   logic [31:0] period;
   int          total = 0, bad = 0;

   tick_sync_monitor #(.SYNC_STAGES(2), .CNT_W(32), .TIMEOUT(100), .TOL(1), .LOCK_COUNT(3)) dut (
      .clk(clk), .rst(rst), .slow_in(slow_in), .tick(tick), .rise(rise), .period(period),
      .period_valid(period_valid), .locked(locked), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // call at a negedge: flip the input and advance to the cycle its tick appears
   task automatic tog();
      slow_in = ~slow_in;
      repeat (3) step();
   endtask

   // from a tick cycle, reach the negedge n cycles after the previous toggle
   task automatic gap(input int n);
      repeat (n - 2) @(negedge clk);
   endtask

   task automatic test_reset();
      int ticks = 0;
      rst = 1'b1;
      slow_in = 1'b0;
      repeat (3) step();
      total++; if ({tick, rise, period_valid, locked, timeout} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {tick, rise, period_valid, locked, timeout}); end
      total++; if (period !== 32'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 99; i++) begin
         step();
         if (tick || locked) ticks++;
      end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL idle_timeout_early got=%b exp=0", timeout); end
      step();
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL idle_timeout got=%b exp=1", timeout); end
      total++; if (ticks !== 0 || locked !== 1'b0) begin bad++; $display("FAIL idle_quiet ticks_or_lock=%0d locked=%b exp=0", ticks, locked); end
   endtask

   task automatic test_lock();
      @(negedge clk);
      tog();
      total++; if ({tick, rise, period_valid, timeout, locked} !== 5'b11000) begin bad++; $display("FAIL first_tick got=%b exp=11000", {tick, rise, period_valid, timeout, locked}); end
      for (int i = 2; i <= 5; i++) begin
         gap(20);
         tog();
         total++; if (period_valid !== 1'b1 || period !== 32'd20) begin bad++; $display("FAIL lock_period%0d got=%0d/%b exp=20/1", i, period, period_valid); end
         total++; if (locked !== (i == 5)) begin bad++; $display("FAIL lock_state%0d got=%b exp=%b", i, locked, i == 5); end
      end
   endtask

   task automatic test_jitter();
      int iv[8]  = '{20, 21, 20, 19, 24, 24, 24, 24};
      bit exp[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         gap(iv[i]);
         tog();
         total++; if (period !== 32'(iv[i]) || period_valid !== 1'b1) begin bad++; $display("FAIL jitter_period%0d got=%0d/%b exp=%0d/1", i, period, period_valid, iv[i]); end
         total++; if (locked !== exp[i]) begin bad++; $display("FAIL jitter_lock%0d got=%b exp=%b", i, locked, exp[i]); end
      end
   endtask

   task automatic test_timeout();
      repeat (99) step();
      total++; if (timeout !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL stall_early got=%b%b exp=01", timeout, locked); end
      step();
      total++; if (timeout !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL stall got=%b%b exp=10", timeout, locked); end
      @(negedge clk);
      tog();
      total++; if ({tick, rise, period_valid, timeout, locked} !== 5'b10000) begin bad++; $display("FAIL recover_tick got=%b exp=10000", {tick, rise, period_valid, timeout, locked}); end
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL recover_single got=%b exp=0", tick); end
   endtask

   task automatic test_edge();
      repeat (8) @(negedge clk);
      slow_in = 1'b1;
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL rise_lat1 got=%b exp=0", tick); end
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL rise_lat2 got=%b exp=0", tick); end
      step();
      total++; if ({tick, rise} !== 2'b11) begin bad++; $display("FAIL rise_lat3 got=%b exp=11", {tick, rise}); end
      step();
      total++; if ({tick, rise} !== 2'b00) begin bad++; $display("FAIL rise_width got=%b exp=00", {tick, rise}); end
      gap(10);
      tog();
      total++; if ({tick, rise} !== 2'b10) begin bad++; $display("FAIL fall_tick got=%b exp=10", {tick, rise}); end
   endtask

   task automatic test_boundary();
      gap(100);
      tog();
      total++; if (timeout !== 1'b0 || period_valid !== 1'b1 || period !== 32'd100) begin bad++; $display("FAIL tick_vs_timeout got=%b/%b/%0d exp=0/1/100", timeout, period_valid, period); end
   endtask

   task automatic test_reset_mid();
      int pv = 0;
      for (int i = 1; i <= 4; i++) begin
         gap(20);
         tog();
         total++; if (locked !== (i == 4)) begin bad++; $display("FAIL relock%0d got=%b exp=%b", i, locked, i == 4); end
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      total++; if ({tick, rise, period_valid, locked, timeout} !== 5'b0 || period !== 32'd0) begin bad++; $display("FAIL midreset got=%b/%0d exp=00000/0", {tick, rise, period_valid, locked, timeout}, period); end
      step();
      @(negedge clk);
      rst = 1'b0;
      step();
      step();
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL spur_early got=%b exp=0", tick); end
      step();
      total++; if ({tick, rise, period_valid} !== 3'b110) begin bad++; $display("FAIL spur_tick got=%b exp=110", {tick, rise, period_valid}); end
      for (int i = 0; i < 10; i++) begin
         step();
         if (period_valid) pv++;
      end
      total++; if (pv !== 0 || period !== 32'd0) begin bad++; $display("FAIL spur_no_period got=%0d/%0d exp=0/0", pv, period); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_jitter();
      test_timeout();
      test_edge();
      test_boundary();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
